irq_exc_ctrl: RTL and testbench
===============================

# irq_exc_ctrl

Parametrised interrupt/exception controller for the pipelined MIPS core, replacing the hard-wired two-source, two-vector interrupt/exception logic in the processor top level. It latches N_IRQ interrupt lines and N_EXC exception sources and arbitrates them by fixed priority. On a take it produces a per-source vector, a pipeline flush and an EPC capture, and it tracks kernel mode. It sits beside the PC-select logic in IF; a small CSR port gives mask, pending, cause and EPC access through the peripheral bus.

## Interface
- N_IRQ, 4: number of interrupt lines (1..16).
- N_EXC, 3: number of exception sources (1..8).
- EDGE_MASK, all ones (N_IRQ bits): 1 makes the line edge-triggered; 0 makes it level-triggered.
- EXC_VEC, 32'h80000008: common exception vector.
- IRQ_VEC_BASE, 32'h80000010: the vector for IRQ k is IRQ_VEC_BASE + 4*k.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- irq_i  in  N_IRQ  interrupt request lines.
- exc_i  in  N_EXC  exception strobes, one cycle each (core hazard, PC overflow, ALU overflow, ...).
- pc_i  in  32  PC4 of the oldest uncommitted instruction; this is the EPC candidate.
- stall_i  in  1  load-use stall; no take is allowed while it is high.
- eret_i  in  1  return-from-handler strobe.
- csr_we  in  1  CSR write enable.
- csr_addr  in  2  CSR select.
- csr_wdata  in  32  CSR write data.
- csr_rdata  out  32  CSR read data (combinational).
- take_o  out  1  one-cycle take pulse; the core flushes IF/ID and ID/EX and loads vector_o into the PC.
- vector_o  out  32  handler address; valid while take_o is high.
- epc_o  out  32  saved return PC; the PC source on eret.
- cause_o  out  CW  last cause, {is_exc, index}. CW = 1 + clog2(max(N_IRQ, N_EXC)).
- kernel_o  out  1  kernel-mode flag.
- err_o  out  2  sticky flags: [0] exception raised while in kernel mode, [1] eret issued while in user mode.

## Operation
- Pending registers:
  - irq_pend for edge lines: set on a 0->1 transition of the registered previous irq_i; cleared by a take of that line or by a CSR W1C.
  - irq_pend for level lines: mirrors the registered irq_i; W1C has no effect on these bits.
  - exc_pend: a set of exc_i bits; cleared only by taking that exception.
- Eligible requests: exceptions always compete. Interrupts compete only when irq_pend & mask is non-zero.
- Arbitration: any exception beats any interrupt. Within a class, the lowest index wins.
- Take condition: eligible request present, kernel_o=0, stall_i=0. On the next edge:
  - take_o=1; vector_o = EXC_VEC or IRQ_VEC_BASE+4*k.
  - epc_o<=pc_i; cause_o<=winner; kernel_o<=1.
  - The winner's pending bit is cleared (edge IRQ or exception).
- Kernel mode: no take occurs. Pending bits keep accumulating. Any new exc_i sets err_o[0] and is also latched as pending.
- eret_i with kernel_o=1: kernel_o<=0 at the next edge. With kernel_o=0: ignored, and err_o[1] is set.
- CSR map:
  - 0 = mask (RW, low N_IRQ bits).
  - 1 = pending ({exc_pend, irq_pend}; W1C on irq edge bits only).
  - 2 = cause (RO).
  - 3 = epc (RO).
  - Unused bits read as 0. Writes to RO CSRs are ignored.

## Timing
- Reset values: mask=0, all pending=0, kernel_o=0, take_o=0, epc_o=0, cause_o=0, err_o=0, previous-irq register=0.
- Latency: an input sampled at edge E0 becomes pending after E0. If the take condition holds in that cycle, take_o is high for the cycle after E1 (2 edges total).
- take_o is registered, lasts exactly one cycle, and is followed by kernel_o=1. Back-to-back takes are impossible.
- A stall delays the take. Pending state is held and nothing is lost.
- Simultaneous events:
  - A new edge and a W1C on the same bit: set wins.
  - A take and a W1C on the same bit: cleared.
  - Mask write in the decision cycle: the decision uses the old mask.
  - eret_i and an eligible request in the same cycle: no take, because kernel is still 1. The take follows one cycle after kernel_o drops.
  - exc_i arriving on the take edge: latched as pending, not lost.
- A reset asserted mid-handler clears kernel_o and all pending bits at that edge.

## Structure
- Package irq_pkg holds:
  - CSR address constants (CSR_MASK, CSR_PEND, CSR_CAUSE, CSR_EPC).
  - Default vector constants.
  - The cause-width function.
- Sub-module irq_prio_enc (parametrised width): a lowest-index-first priority encoder returning valid and index. It is instantiated twice, once for exceptions and once for masked IRQs.

## Test plan
- Reset, then write mask=4'b1111, then pulse irq_i[2] for one cycle -> take_o 2 cycles later, vector_o=32'h80000018, cause_o={0,2}, kernel_o=1, epc_o=pc_i.
- exc_i[1] and irq_i[0] in the same cycle -> exception wins, vector_o=32'h80000008, cause_o={1,1}. After eret_i, the IRQ 0 take follows on the cycle after kernel_o drops.
- stall_i held high for 3 cycles with irq_i[1] pending -> no take during the stall; take on the first cycle after the stall releases.
- exc_i[0] while kernel_o=1 -> err_o[0]=1, no take. After eret_i, the exception is taken (pending preserved).
- Level line (EDGE_MASK bit 3=0) held high, mask bit 3 set -> take. After eret, a second take occurs while the line stays high; W1C on pending bit 3 does not clear it.
- eret_i with kernel_o=0 -> err_o[1]=1 and no state change. A reset mid-handler -> kernel_o=0 and pending=0 on the next cycle.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt/exception controller.
package irq_pkg;

    // CSR select codes on the peripheral-bus port
    typedef enum logic [1:0] {
        CSR_MASK  = 2'd0,
        CSR_PEND  = 2'd1,
        CSR_CAUSE = 2'd2,
        CSR_EPC   = 2'd3
    } csr_addr_e;

    localparam logic [31:0] DEF_EXC_VEC      = 32'h8000_0008;
    localparam logic [31:0] DEF_IRQ_VEC_BASE = 32'h8000_0010;

    // Width of the cause field: {is_exc, index}. The index field is kept at
    // least one bit wide so single-source configurations still elaborate.
    function automatic int unsigned irq_cause_width(input int unsigned n_irq,
                                                    input int unsigned n_exc);
        int unsigned m;
        m = (n_irq > n_exc) ? n_irq : n_exc;
        if (m < 2) m = 2;
        return 1 + $clog2(m);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set
// and the index of the lowest set request.
module irq_prio_enc #(
    parameter int unsigned W  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [W-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan upward; the first set bit found is kept
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_exc_ctrl.sv
// Interrupt/exception controller: latches IRQ lines and exception strobes,
// arbitrates by fixed priority (exceptions first, lowest index first), and
// issues a registered take pulse with vector, EPC capture and kernel-mode entry.
module irq_exc_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned       N_IRQ        = 4,
    parameter int unsigned       N_EXC        = 3,
    parameter logic [N_IRQ-1:0]  EDGE_MASK    = '1,
    parameter logic [31:0]       EXC_VEC      = DEF_EXC_VEC,
    parameter logic [31:0]       IRQ_VEC_BASE = DEF_IRQ_VEC_BASE,
    localparam int unsigned      CW           = irq_cause_width(N_IRQ, N_EXC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IRQ-1:0]  irq_i,
    input  logic [N_EXC-1:0]  exc_i,
    input  logic [31:0]       pc_i,
    input  logic              stall_i,
    input  logic              eret_i,
    input  logic              csr_we,
    input  logic [1:0]        csr_addr,
    input  logic [31:0]       csr_wdata,
    output logic [31:0]       csr_rdata,
    output logic              take_o,
    output logic [31:0]       vector_o,
    output logic [31:0]       epc_o,
    output logic [CW-1:0]     cause_o,
    output logic              kernel_o,
    output logic [1:0]        err_o
);

    localparam int unsigned IW = CW - 1;

    logic [N_IRQ-1:0] mask_q,      mask_d;
    logic [N_IRQ-1:0] pend_edge_q, pend_edge_d;
    logic [N_IRQ-1:0] irq_prev_q,  irq_prev_d;
    logic [N_EXC-1:0] exc_pend_q,  exc_pend_d;
    logic             kernel_q,    kernel_d;
    logic             take_q,      take_d;
    logic [31:0]      vector_q,    vector_d;
    logic [31:0]      epc_q,       epc_d;
    logic [CW-1:0]    cause_q,     cause_d;
    logic [1:0]       err_q,       err_d;

    logic [N_IRQ-1:0] irq_pend;
    logic [N_IRQ-1:0] irq_elig;
    logic             exc_valid, irq_valid;
    logic [IW-1:0]    exc_idx,   irq_idx;
    logic             take_exc,  take_irq;
    logic [N_IRQ-1:0] irq_take_oh;
    logic [N_EXC-1:0] exc_take_oh;
    logic [N_IRQ-1:0] w1c;

    // Level lines report the registered input directly; edge lines report the latch
    assign irq_pend = (pend_edge_q & EDGE_MASK) | (irq_prev_q & ~EDGE_MASK);
    assign irq_elig = irq_pend & mask_q;

    irq_prio_enc #(.W(N_EXC), .IW(IW)) u_exc_enc (
        .req   (exc_pend_q),
        .valid (exc_valid),
        .idx   (exc_idx)
    );

    irq_prio_enc #(.W(N_IRQ), .IW(IW)) u_irq_enc (
        .req   (irq_elig),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    // Take decision and winner one-hot clear masks
    always_comb begin
        take_exc = exc_valid && !kernel_q && !stall_i;
        take_irq = !exc_valid && irq_valid && !kernel_q && !stall_i;
        irq_take_oh = '0;
        exc_take_oh = '0;
        for (int unsigned k = 0; k < N_IRQ; k++)
            irq_take_oh[k] = take_irq && (irq_idx == IW'(k));
        for (int unsigned j = 0; j < N_EXC; j++)
            exc_take_oh[j] = take_exc && (exc_idx == IW'(j));
        w1c = (csr_we && csr_addr == CSR_PEND) ? csr_wdata[N_IRQ-1:0] : '0;
    end

    // Next-state computation for all controller registers
    always_comb begin
        mask_d      = mask_q;
        vector_d    = vector_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        kernel_d    = kernel_q;
        take_d      = take_exc || take_irq;
        irq_prev_d  = irq_i;
        // A new rising edge wins over both the take clear and a W1C
        pend_edge_d = ((pend_edge_q & ~w1c & ~irq_take_oh) | (irq_i & ~irq_prev_q)) & EDGE_MASK;
        exc_pend_d  = (exc_pend_q & ~exc_take_oh) | exc_i;
        err_d       = err_q | {eret_i && !kernel_q, kernel_q && (|exc_i)};

        if (csr_we && csr_addr == CSR_MASK)
            mask_d = csr_wdata[N_IRQ-1:0];

        if (take_exc) begin
            vector_d = EXC_VEC;
            cause_d  = {1'b1, exc_idx};
            epc_d    = pc_i;
            kernel_d = 1'b1;
        end else if (take_irq) begin
            vector_d = IRQ_VEC_BASE + (32'(irq_idx) << 2);
            cause_d  = {1'b0, irq_idx};
            epc_d    = pc_i;
            kernel_d = 1'b1;
        end else if (eret_i && kernel_q) begin
            kernel_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q      <= '0;
            pend_edge_q <= '0;
            irq_prev_q  <= '0;
            exc_pend_q  <= '0;
            kernel_q    <= 1'b0;
            take_q      <= 1'b0;
            vector_q    <= '0;
            epc_q       <= '0;
            cause_q     <= '0;
            err_q       <= '0;
        end else begin
            mask_q      <= mask_d;
            pend_edge_q <= pend_edge_d;
            irq_prev_q  <= irq_prev_d;
            exc_pend_q  <= exc_pend_d;
            kernel_q    <= kernel_d;
            take_q      <= take_d;
            vector_q    <= vector_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            err_q       <= err_d;
        end
    end

    // Combinational CSR read mux; unused bits read as zero
    always_comb begin
        csr_rdata = '0;
        unique case (csr_addr_e'(csr_addr))
            CSR_MASK:  csr_rdata[N_IRQ-1:0]       = mask_q;
            CSR_PEND:  csr_rdata[N_IRQ+N_EXC-1:0] = {exc_pend_q, irq_pend};
            CSR_CAUSE: csr_rdata[CW-1:0]          = cause_q;
            CSR_EPC:   csr_rdata                  = epc_q;
            default:   csr_rdata                  = '0;
        endcase
    end

    assign take_o   = take_q;
    assign vector_o = vector_q;
    assign epc_o    = epc_q;
    assign cause_o  = cause_q;
    assign kernel_o = kernel_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// Bench for irq_exc_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the controller rules.
module tb_irq_exc_ctrl;
    import irq_pkg::*;

    localparam int unsigned N_IRQ = 4;
    localparam int unsigned N_EXC = 3;
    localparam logic [N_IRQ-1:0] EDGE_CFG = 4'b0111;
    localparam int unsigned CW = irq_cause_width(N_IRQ, N_EXC);

    logic              clk = 1'b0;
    logic              reset;
    logic [N_IRQ-1:0]  irq;
    logic [N_EXC-1:0]  exc;
    logic [31:0]       pc;
    logic              stall, eret, we;
    logic [1:0]        addr;
    logic [31:0]       wdata;
    logic [31:0]       csr_rdata, vector_o, epc_o;
    logic              take_o, kernel_o;
    logic [CW-1:0]     cause_o;
    logic [1:0]        err_o;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    irq_exc_ctrl #(
        .N_IRQ        (N_IRQ),
        .N_EXC        (N_EXC),
        .EDGE_MASK    (EDGE_CFG),
        .EXC_VEC      (32'h8000_0008),
        .IRQ_VEC_BASE (32'h8000_0010)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_i     (irq),
        .exc_i     (exc),
        .pc_i      (pc),
        .stall_i   (stall),
        .eret_i    (eret),
        .csr_we    (we),
        .csr_addr  (addr),
        .csr_wdata (wdata),
        .csr_rdata (csr_rdata),
        .take_o    (take_o),
        .vector_o  (vector_o),
        .epc_o     (epc_o),
        .cause_o   (cause_o),
        .kernel_o  (kernel_o),
        .err_o     (err_o)
    );

    // Behavioural model state (one int per source bit)
    int m_mask[N_IRQ];
    int m_pe[N_IRQ];
    int m_prev[N_IRQ];
    int m_xp[N_EXC];
    int m_kernel = 0, m_take = 0, m_err0 = 0, m_err1 = 0, m_cause = 0;
    logic [31:0] m_vec = '0, m_epc = '0;
    logic [N_IRQ-1:0] edge_cfg = EDGE_CFG;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pend_bit(input int k);
        return edge_cfg[k] ? m_pe[k] : m_prev[k];
    endfunction

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: for (int k = 0; k < N_IRQ; k++) r[k] = (m_mask[k] != 0);
            2'd1: begin
                for (int k = 0; k < N_IRQ; k++) r[k] = (pend_bit(k) != 0);
                for (int j = 0; j < N_EXC; j++) r[N_IRQ+j] = (m_xp[j] != 0);
            end
            2'd2: r = 32'(m_cause);
            default: r = m_epc;
        endcase
        return r;
    endfunction

    // Advance the model by one clock using the inputs currently driven
    task automatic model_update();
        int win_exc, win_irq, tk;
        if (reset) begin
            for (int k = 0; k < N_IRQ; k++) begin m_mask[k] = 0; m_pe[k] = 0; m_prev[k] = 0; end
            for (int j = 0; j < N_EXC; j++) m_xp[j] = 0;
            m_kernel = 0; m_take = 0; m_err0 = 0; m_err1 = 0; m_cause = 0;
            m_vec = '0; m_epc = '0;
            return;
        end
        win_exc = -1;
        for (int j = 0; j < N_EXC; j++) if (m_xp[j] != 0 && win_exc < 0) win_exc = j;
        win_irq = -1;
        for (int k = 0; k < N_IRQ; k++)
            if (pend_bit(k) != 0 && m_mask[k] != 0 && win_irq < 0) win_irq = k;
        tk = ((win_exc >= 0 || win_irq >= 0) && m_kernel == 0 && !stall) ? 1 : 0;

        if (m_kernel != 0 && exc != 0) m_err0 = 1;
        if (eret && m_kernel == 0) m_err1 = 1;

        for (int j = 0; j < N_EXC; j++)
            if (exc[j]) m_xp[j] = 1;
            else if (tk != 0 && win_exc == j) m_xp[j] = 0;

        for (int k = 0; k < N_IRQ; k++)
            if (edge_cfg[k]) begin
                if (irq[k] && m_prev[k] == 0) m_pe[k] = 1;
                else if ((tk != 0 && win_exc < 0 && win_irq == k) ||
                         (we && addr == 2'd1 && wdata[k])) m_pe[k] = 0;
            end
        for (int k = 0; k < N_IRQ; k++) m_prev[k] = irq[k] ? 1 : 0;

        if (we && addr == 2'd0)
            for (int k = 0; k < N_IRQ; k++) m_mask[k] = wdata[k] ? 1 : 0;

        m_take = tk;
        if (tk != 0) begin
            m_kernel = 1;
            m_epc = pc;
            if (win_exc >= 0) begin
                m_vec = 32'h8000_0008;
                m_cause = (1 << (CW - 1)) + win_exc;
            end else begin
                m_vec = 32'h8000_0010 + 32'(4 * win_irq);
                m_cause = win_irq;
            end
        end else if (eret && m_kernel != 0) begin
            m_kernel = 0;
        end
    endtask

    // One clock: update model, let the edge pass, compare outputs
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("take", 32'(take_o), 32'(m_take));
        check("kernel", 32'(kernel_o), 32'(m_kernel));
        check("epc", epc_o, m_epc);
        check("cause", 32'(cause_o), 32'(m_cause));
        check("err", 32'(err_o), 32'({m_err1 != 0, m_err0 != 0}));
        check("rdata", csr_rdata, model_rdata(addr));
        if (m_take != 0) check("vector", vector_o, m_vec);
    endtask

    task automatic quiet();
        irq = '0; exc = '0; stall = 1'b0; eret = 1'b0; we = 1'b0; wdata = '0;
    endtask

    initial begin
        reset = 1'b1; quiet(); pc = 32'h0000_0100; addr = 2'd0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_kernel", 32'(kernel_o), 32'd0);
        check("rst_take", 32'(take_o), 32'd0);
        check("rst_mask", csr_rdata, 32'd0);

        // Enable all lines, then a one-cycle pulse on IRQ 2
        we = 1'b1; addr = 2'd0; wdata = 32'hF; step(); we = 1'b0; addr = 2'd1;
        pc = 32'h0000_0400; irq = 4'b0100; step(); irq = '0; step();
        check("t1_take", 32'(take_o), 32'd1);
        check("t1_vec", vector_o, 32'h8000_0018);
        check("t1_cause", 32'(cause_o), 32'b010);
        check("t1_kernel", 32'(kernel_o), 32'd1);
        check("t1_epc", epc_o, 32'h0000_0400);
        step();
        check("t1_pulse1", 32'(take_o), 32'd0);
        eret = 1'b1; step(); eret = 1'b0;
        check("t1_eret", 32'(kernel_o), 32'd0);

        // Exception beats a simultaneous interrupt; the IRQ follows after eret
        pc = 32'h0000_0500; exc = 3'b010; irq = 4'b0001; step(); quiet(); step();
        check("t2_vec", vector_o, 32'h8000_0008);
        check("t2_cause", 32'(cause_o), 32'b101);
        eret = 1'b1; step(); eret = 1'b0;
        step();
        check("t2_irq_take", 32'(take_o), 32'd1);
        check("t2_irq_vec", vector_o, 32'h8000_0010);
        eret = 1'b1; step(); eret = 1'b0; step();

        // Stall holds off a pending IRQ 1
        stall = 1'b1; irq = 4'b0010; step(); irq = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_stalled", 32'(take_o), 32'd0);
        end
        stall = 1'b0; step();
        check("t3_take", 32'(take_o), 32'd1);
        check("t3_vec", vector_o, 32'h8000_0014);
        eret = 1'b1; step(); eret = 1'b0; step();

        // Exception raised in kernel mode is flagged and kept pending
        irq = 4'b0001; step(); irq = '0; step();
        exc = 3'b001; step(); exc = '0;
        check("t4_err0", 32'(err_o[0]), 32'd1);
        check("t4_notake", 32'(take_o), 32'd0);
        step();
        eret = 1'b1; step(); eret = 1'b0; step();
        check("t4_take", 32'(take_o), 32'd1);
        check("t4_cause", 32'(cause_o), 32'b100);
        eret = 1'b1; step(); eret = 1'b0; step();

        // Level line 3 retriggers after eret and ignores W1C
        irq = 4'b1000; step(); step();
        check("t5_take", 32'(take_o), 32'd1);
        check("t5_vec", vector_o, 32'h8000_001C);
        eret = 1'b1; step(); eret = 1'b0; step();
        check("t5_retake", 32'(take_o), 32'd1);
        irq = 4'b1100; step();
        we = 1'b1; addr = 2'd1; wdata = 32'hC; step(); we = 1'b0;
        check("t5_w1c", csr_rdata & 32'hC, 32'h8);
        irq = '0; step();
        eret = 1'b1; step(); eret = 1'b0; step();
        while (kernel_o) begin eret = 1'b1; step(); eret = 1'b0; step(); end

        // eret in user mode, then reset in the middle of a handler
        eret = 1'b1; step(); eret = 1'b0;
        check("t6_err1", 32'(err_o[1]), 32'd1);
        check("t6_kernel", 32'(kernel_o), 32'd0);
        irq = 4'b0001; step(); irq = '0; step();
        check("t6_in_handler", 32'(kernel_o), 32'd1);
        irq = 4'b0100; step(); irq = '0;
        reset = 1'b1; addr = 2'd1; step(); reset = 1'b0;
        check("t6_rst_kernel", 32'(kernel_o), 32'd0);
        check("t6_rst_pend", csr_rdata, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            irq   = N_IRQ'($urandom);
            exc   = ($urandom_range(0, 5) == 0) ? N_EXC'($urandom) : '0;
            pc    = $urandom;
            stall = ($urandom_range(0, 3) == 0);
            eret  = ($urandom_range(0, 5) == 0);
            we    = ($urandom_range(0, 7) == 0);
            addr  = 2'($urandom);
            wdata = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
